model_tensor_float_feeder: RTL and testbench

- Upstream stage of the tensor float adder: pairs two scalar element streams (A and B) and presents them as one tensor walk.
- Walk order is row-major over SIZE_I x SIZE_J x SIZE_K, with k fastest.
- Generates the per-element I/J/K enable strobes that the adder's DATA_A/B_IN_*_ENABLE inputs expect.
- Has valid/ready flow control on both sides, so memory-side sources and the adder can stall independently.

---
 rtl/model_tensor_float_feeder.sv | 184 ++++++++++++++++++
 tb/tb_model_tensor_float_feeder.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/model_tensor_float_feeder.sv
// Pairs the A and B element streams into one row-major I x J x K tensor walk (k fastest) for the tensor float adder.
// Optional synchronous ABORT input is enabled by defining MODEL_TENSOR_FLOAT_FEEDER_ABORT_EN.
module model_tensor_float_feeder #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [DATA_SIZE-1:0] SIZE_I_IN,
  input  logic [DATA_SIZE-1:0] SIZE_J_IN,
  input  logic [DATA_SIZE-1:0] SIZE_K_IN,
  input  logic [DATA_SIZE-1:0] DATA_A_IN,
  input  logic                 DATA_A_VALID,
  input  logic [DATA_SIZE-1:0] DATA_B_IN,
  input  logic                 DATA_B_VALID,
  output logic                 DATA_IN_READY,
  output logic [DATA_SIZE-1:0] DATA_A_OUT,
  output logic [DATA_SIZE-1:0] DATA_B_OUT,
  output logic                 DATA_OUT_VALID,
  input  logic                 DATA_OUT_ACCEPT,
  output logic                 DATA_OUT_I_ENABLE,
  output logic                 DATA_OUT_J_ENABLE,
  output logic                 DATA_OUT_K_ENABLE,
`ifdef MODEL_TENSOR_FLOAT_FEEDER_ABORT_EN
  input  logic                 ABORT,
`endif
  output logic [1:0]           state_debug
);

  typedef enum logic [1:0] {
    STARTER_STATE = 2'd0,
    STREAM_STATE  = 2'd1,
    ENDER_STATE   = 2'd2
  } state_t;

  localparam logic [CONTROL_SIZE-1:0] CTRL_ONE = CONTROL_SIZE'(1);

  state_t                  state;
  state_t                  next_state;
  logic [DATA_SIZE-1:0]    size_i;
  logic [DATA_SIZE-1:0]    size_j;
  logic [DATA_SIZE-1:0]    size_k;
  logic [CONTROL_SIZE-1:0] cnt_i;
  logic [CONTROL_SIZE-1:0] cnt_j;
  logic [CONTROL_SIZE-1:0] cnt_k;
  logic                    last_popped;
  logic                    abort;
  logic                    pop;
  logic                    last_i;
  logic                    last_j;
  logic                    last_k;
  logic                    empty_walk;

`ifdef MODEL_TENSOR_FLOAT_FEEDER_ABORT_EN
  assign abort = ABORT;
`else
  assign abort = 1'b0;
`endif

  assign state_debug = state;

  // Sizes are only ever compared on their low CONTROL_SIZE bits (CONTROL_SIZE <= DATA_SIZE).
  assign last_i = (cnt_i == size_i[CONTROL_SIZE-1:0] - CTRL_ONE);
  assign last_j = (cnt_j == size_j[CONTROL_SIZE-1:0] - CTRL_ONE);
  assign last_k = (cnt_k == size_k[CONTROL_SIZE-1:0] - CTRL_ONE);
  assign empty_walk = (SIZE_I_IN[CONTROL_SIZE-1:0] == '0) ||
                      (SIZE_J_IN[CONTROL_SIZE-1:0] == '0) ||
                      (SIZE_K_IN[CONTROL_SIZE-1:0] == '0);

  // Handshakes: an input pair transfers on a rising edge where DATA_IN_READY, DATA_A_VALID and
  // DATA_B_VALID are all high; an output element transfers where DATA_OUT_VALID and DATA_OUT_ACCEPT
  // are both high. DATA_IN_READY never looks at the input valids, and the output holds while stalled.
  assign pop = DATA_IN_READY && DATA_A_VALID && DATA_B_VALID;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= STARTER_STATE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state    = state;
    DATA_IN_READY = 1'b0;
    case (state)
      STARTER_STATE: begin
        if (START) begin
          next_state = empty_walk ? ENDER_STATE : STREAM_STATE;
        end
      end
      STREAM_STATE: begin
        DATA_IN_READY = (!DATA_OUT_VALID || DATA_OUT_ACCEPT) && !last_popped && !abort;
        if (last_popped && DATA_OUT_VALID && DATA_OUT_ACCEPT) begin
          next_state = ENDER_STATE;
        end
      end
      ENDER_STATE: begin
        next_state = STARTER_STATE;
      end
      default: begin
        next_state = STARTER_STATE;
      end
    endcase
    if (abort) begin
      next_state = STARTER_STATE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      READY             <= 1'b0;
      size_i            <= '0;
      size_j            <= '0;
      size_k            <= '0;
      cnt_i             <= '0;
      cnt_j             <= '0;
      cnt_k             <= '0;
      last_popped       <= 1'b0;
      DATA_A_OUT        <= '0;
      DATA_B_OUT        <= '0;
      DATA_OUT_VALID    <= 1'b0;
      DATA_OUT_I_ENABLE <= 1'b0;
      DATA_OUT_J_ENABLE <= 1'b0;
      DATA_OUT_K_ENABLE <= 1'b0;
    end else begin
      READY <= (state == ENDER_STATE) && !abort;
      if (abort) begin
        cnt_i             <= '0;
        cnt_j             <= '0;
        cnt_k             <= '0;
        last_popped       <= 1'b0;
        DATA_OUT_VALID    <= 1'b0;
        DATA_OUT_I_ENABLE <= 1'b0;
        DATA_OUT_J_ENABLE <= 1'b0;
        DATA_OUT_K_ENABLE <= 1'b0;
      end else if (state == STARTER_STATE) begin
        if (START) begin
          size_i      <= SIZE_I_IN;
          size_j      <= SIZE_J_IN;
          size_k      <= SIZE_K_IN;
          cnt_i       <= '0;
          cnt_j       <= '0;
          cnt_k       <= '0;
          last_popped <= 1'b0;
        end
      end else if (state == STREAM_STATE) begin
        if (pop) begin
          DATA_A_OUT        <= DATA_A_IN;
          DATA_B_OUT        <= DATA_B_IN;
          DATA_OUT_VALID    <= 1'b1;
          DATA_OUT_I_ENABLE <= (cnt_j == '0) && (cnt_k == '0);
          DATA_OUT_J_ENABLE <= (cnt_k == '0);
          DATA_OUT_K_ENABLE <= 1'b1;
          // The final pop wraps every counter back to zero so none ever exceeds size-1.
          if (last_k) begin
            cnt_k <= '0;
            if (last_j) begin
              cnt_j <= '0;
              if (last_i) begin
                cnt_i       <= '0;
                last_popped <= 1'b1;
              end else begin
                cnt_i <= cnt_i + CTRL_ONE;
              end
            end else begin
              cnt_j <= cnt_j + CTRL_ONE;
            end
          end else begin
            cnt_k <= cnt_k + CTRL_ONE;
          end
        end else if (DATA_OUT_ACCEPT) begin
          DATA_OUT_VALID    <= 1'b0;
          DATA_OUT_I_ENABLE <= 1'b0;
          DATA_OUT_J_ENABLE <= 1'b0;
          DATA_OUT_K_ENABLE <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_model_tensor_float_feeder.sv
// Bench for model_tensor_float_feeder: queue-fed A/B sources, scoreboard of {A, B, I, J, K} per element.
module tb_model_tensor_float_feeder;

  localparam int DW = 64;
  localparam int SW = 2 * DW + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          ready;
  logic [DW-1:0] size_i;
  logic [DW-1:0] size_j;
  logic [DW-1:0] size_k;
  logic [DW-1:0] a_data;
  logic          a_valid;
  logic [DW-1:0] b_data;
  logic          b_valid;
  logic          in_ready;
  logic [DW-1:0] a_out;
  logic [DW-1:0] b_out;
  logic          out_valid;
  logic          accept;
  logic          i_en;
  logic          j_en;
  logic          k_en;
  logic [1:0]    state_dbg;
`ifdef MODEL_TENSOR_FLOAT_FEEDER_ABORT_EN
  logic          abort;
`endif

  model_tensor_float_feeder #(.DATA_SIZE(DW), .CONTROL_SIZE(DW)) dut (
    .CLK               (clk),
    .RST               (rst),
    .START             (start),
    .READY             (ready),
    .SIZE_I_IN         (size_i),
    .SIZE_J_IN         (size_j),
    .SIZE_K_IN         (size_k),
    .DATA_A_IN         (a_data),
    .DATA_A_VALID      (a_valid),
    .DATA_B_IN         (b_data),
    .DATA_B_VALID      (b_valid),
    .DATA_IN_READY     (in_ready),
    .DATA_A_OUT        (a_out),
    .DATA_B_OUT        (b_out),
    .DATA_OUT_VALID    (out_valid),
    .DATA_OUT_ACCEPT   (accept),
    .DATA_OUT_I_ENABLE (i_en),
    .DATA_OUT_J_ENABLE (j_en),
    .DATA_OUT_K_ENABLE (k_en),
`ifdef MODEL_TENSOR_FLOAT_FEEDER_ABORT_EN
    .ABORT             (abort),
`endif
    .state_debug       (state_dbg)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] src_a[$];
  logic [DW-1:0] src_b[$];
  logic [SW-1:0] exp_q[$];
  int            acc_cyc_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int ready_cnt = 0;
  int ready_cyc = 0;
  int acc_total = 0;
  int hold_seen = 0;
  int acc_base = 0;
  int ready_base = 0;
  int hold_base = 0;
  int start_cyc = 0;
  int hold_req = 0;
  bit b_gap = 1'b0;

  task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // ---------------- source driver + output monitor ----------------
  initial begin
    bit popped;
    bit phase;
    int hold_done;
    logic [SW-1:0] got;
    logic [SW-1:0] e;
    popped = 1'b0;
    phase = 1'b0;
    hold_done = 0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_data = '0;
    b_data = '0;
    accept = 1'b1;
    forever begin
      @(negedge clk);
      popped = 1'b0;
      if (!rst) begin
        popped = in_ready && a_valid && b_valid;
        if (ready) begin
          ready_cnt++;
          ready_cyc = cyc;
        end
        got = {a_out, b_out, i_en, j_en, k_en};
        if (out_valid && accept) begin
          acc_total++;
          acc_cyc_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            check("extra_out", SW'(1), SW'(0));
          end else begin
            e = exp_q.pop_front();
            check("elem", got, e);
          end
        end else if (out_valid && exp_q.size() > 0) begin
          hold_seen++;
          check("hold_data", got, exp_q[0]);
          check("hold_inrdy", SW'(in_ready), '0);
        end
      end
      @(posedge clk);
      #1;
      if (popped && src_a.size() > 0) begin
        void'(src_a.pop_front());
        void'(src_b.pop_front());
      end
      phase = ~phase;
      a_valid = (src_a.size() > 0);
      b_valid = (src_b.size() > 0) && !(b_gap && phase);
      a_data = (src_a.size() > 0) ? src_a[0] : '0;
      b_data = (src_b.size() > 0) ? src_b[0] : '0;
      if (hold_req == 0) hold_done = 0;
      if (out_valid && hold_done < hold_req) begin
        accept = 1'b0;
        hold_done++;
      end else begin
        accept = 1'b1;
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic start_walk(input int si, input int sj, input int sk, input int a0, input int b0);
    int n = 0;
    for (int i = 0; i < si; i++) begin
      for (int j = 0; j < sj; j++) begin
        for (int k = 0; k < sk; k++) begin
          src_a.push_back(DW'(a0 + n));
          src_b.push_back(DW'(b0 + n));
          exp_q.push_back({DW'(a0 + n), DW'(b0 + n), ((j == 0) && (k == 0)), (k == 0), 1'b1});
          n++;
        end
      end
    end
    acc_base = acc_total;
    ready_base = ready_cnt;
    hold_base = hold_seen;
    @(posedge clk);
    #1;
    start = 1'b1;
    size_i = DW'(si);
    size_j = DW'(sj);
    size_k = DW'(sk);
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble the size inputs: the walk must run on the latched values.
    size_i = DW'($urandom_range(1, 7));
    size_j = DW'($urandom_range(1, 7));
    size_k = DW'($urandom_range(1, 7));
  endtask

  task automatic wait_done(input int budget);
    bit ok = 1'b0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && ready_cnt > ready_base) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("done_timeout", SW'(0), SW'(1));
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic wait_acc(input int n, input int budget);
    bit ok = 1'b0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      #1;
      if (acc_total - acc_base >= n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("acc_timeout", SW'(0), SW'(1));
  endtask

  // ---------------- scenarios ----------------
  initial begin
    rst = 1'b1;
    start = 1'b0;
    size_i = '0;
    size_j = '0;
    size_k = '0;
`ifdef MODEL_TENSOR_FLOAT_FEEDER_ABORT_EN
    abort = 1'b0;
`endif
    #3;
    check("rst_ctl", SW'({ready, in_ready, out_valid, i_en, j_en, k_en}), '0);
    check("rst_a", SW'(a_out), '0);
    check("rst_b", SW'(b_out), '0);
    check("rst_state", SW'(state_dbg), '0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // 2x2x3, free-flowing on both sides
    start_walk(2, 2, 3, 1, 101);
    wait_done(200);
    check("s1_count", SW'(acc_total - acc_base), SW'(12));
    check("s1_burst", SW'(acc_cyc_q[acc_total - 1] - acc_cyc_q[acc_base]), SW'(11));
    check("s1_ready_n", SW'(ready_cnt - ready_base), SW'(1));
    // READY rises on the edge after the edge that takes the last element.
    check("s1_ready_lat", SW'(ready_cyc - acc_cyc_q[acc_total - 1]), SW'(2));

    // same walk, B valid only every other cycle
    b_gap = 1'b1;
    start_walk(2, 2, 3, 1, 101);
    wait_done(300);
    b_gap = 1'b0;
    check("s2_count", SW'(acc_total - acc_base), SW'(12));
    check("s2_span", SW'((acc_cyc_q[acc_total - 1] - acc_cyc_q[acc_base]) >= 22), SW'(1));
    check("s2_ready_n", SW'(ready_cnt - ready_base), SW'(1));

    // 1x1x4 with a 3-cycle downstream stall on the first element
    hold_req = 3;
    start_walk(1, 1, 4, 41, 141);
    wait_done(200);
    hold_req = 0;
    check("s3_count", SW'(acc_total - acc_base), SW'(4));
    check("s3_hold", SW'(hold_seen - hold_base), SW'(3));
    check("s3_ready_n", SW'(ready_cnt - ready_base), SW'(1));

    // empty walk: SIZE_J = 0
    start_walk(1, 0, 3, 51, 151);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      #1;
      check("s4_inrdy", SW'(in_ready), '0);
      check("s4_valid", SW'(out_valid), '0);
    end
    check("s4_ready_n", SW'(ready_cnt - ready_base), SW'(1));
    check("s4_ready_lat", SW'(ready_cyc - start_cyc), SW'(2));
    check("s4_count", SW'(acc_total - acc_base), '0);

    // 2x2x2 interrupted by reset after the third element
    start_walk(2, 2, 2, 21, 221);
    wait_acc(3, 100);
    check("s5_pre_valid", SW'(out_valid), SW'(1));
    rst = 1'b1;
    #1;
    check("s5_rst_ctl", SW'({ready, in_ready, out_valid, i_en, j_en, k_en}), '0);
    check("s5_rst_a", SW'(a_out), '0);
    check("s5_rst_b", SW'(b_out), '0);
    @(posedge clk);
    #2;
    src_a.delete();
    src_b.delete();
    exp_q.delete();
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("s5_no_ready", SW'(ready_cnt - ready_base), '0);
    start_walk(2, 2, 2, 31, 231);
    wait_done(200);
    check("s5_count", SW'(acc_total - acc_base), SW'(8));
    check("s5_ready_n", SW'(ready_cnt - ready_base), SW'(1));

`ifdef MODEL_TENSOR_FLOAT_FEEDER_ABORT_EN
    // 2x2x2 aborted in the cycle the 5th element would pop
    start_walk(2, 2, 2, 71, 271);
    wait_acc(3, 100);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("s6_valid", SW'(out_valid), '0);
    check("s6_state", SW'(state_dbg), '0);
    src_a.delete();
    src_b.delete();
    exp_q.delete();
    repeat (4) @(negedge clk);
    #1;
    check("s6_no_ready", SW'(ready_cnt - ready_base), '0);
    check("s6_count", SW'(acc_total - acc_base), SW'(4));
    start_walk(1, 1, 1, 81, 181);
    wait_done(100);
    check("s6_after_count", SW'(acc_total - acc_base), SW'(1));
    check("s6_after_ready", SW'(ready_cnt - ready_base), SW'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
